music_tone_gen: RTL and testbench

MUSIC_TONE_GEN -- requirements
Module: music_tone_gen

---
 rtl/music_tone_gen.sv | 96 +++++++++
 tb/tb_music_tone_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_tone_gen.sv
// music_tone_gen: square-wave tone generator with serial period divider and glitch-free period swap
module music_tone_gen #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned MIN_HZ = 20,
  parameter int unsigned MAX_HZ = 19999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] tone,
  input  logic [2:0]  volume,
  output logic        audio_out,
  output logic        note_on,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [31:0] SILENCE  = 32'd20000;
  state_t      state_q, state_d;
  logic [31:0] tone_q, tone_act_q, tone_act_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] pend_period_q, pend_period_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] period_q, period_d, high_len_q, high_len_d, cnt_q, cnt_d;
  logic        note_on_q, note_on_d;
  logic [32:0] sh;
  logic        audible, changed, ge, div_start, mark_silent, div_done;
  logic        mute, wrap, load;
  logic [31:0] hl_next;
  assign audible = tone_q >= MIN_HZ && tone_q <= MAX_HZ;
  assign changed = tone_q != tone_act_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tone_q        <= SILENCE;
      tone_act_q    <= SILENCE;
      quo_q         <= '0;
      rem_q         <= '0;
      bit_q         <= '0;
      pend_period_q <= '0;
      pend_valid_q  <= 1'b0;
      period_q      <= '0;
      high_len_q    <= '0;
      cnt_q         <= '0;
      note_on_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tone_q        <= tone;
      tone_act_q    <= tone_act_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      bit_q         <= bit_d;
      pend_period_q <= pend_period_d;
      pend_valid_q  <= pend_valid_d;
      period_q      <= period_d;
      high_len_q    <= high_len_d;
      cnt_q         <= cnt_d;
      note_on_q     <= note_on_d;
    end
  end
  // any tone change restarts (audible) or abandons (silent) the divide, whatever the state
  always_comb begin
    state_d = changed ? (audible ? DIV : IDLE)
            : state_q == DIV ? (bit_q == 5'd31 ? DONE : DIV)
            : IDLE;
  end
  always_comb begin
    div_start     = changed && audible;
    mark_silent   = state_q == IDLE && changed && !audible;
    div_done      = state_q == DONE && !changed;
    tone_act_d    = (div_start || mark_silent) ? tone_q : tone_act_q;
    sh            = {rem_q, quo_q[31]};
    ge            = sh >= {1'b0, tone_act_q};
    rem_d         = div_start ? '0 : state_q == DIV ? 32'(ge ? sh - {1'b0, tone_act_q} : sh) : rem_q;
    quo_d         = div_start ? DIVIDEND : state_q == DIV ? {quo_q[30:0], ge} : quo_q;
    bit_d         = div_start ? '0 : state_q == DIV ? bit_q + 5'd1 : bit_q;
    mute          = !en || volume == 3'd0 || period_q == '0;
    wrap          = note_on_q && cnt_q == period_q - 32'd1;
    load          = pend_valid_q && (mute || wrap);
    pend_period_d = div_done ? quo_q : mark_silent ? '0 : pend_period_q;
    pend_valid_d  = div_done || mark_silent || (pend_valid_q && !load);
    period_d      = load ? pend_period_q : period_q;
    hl_next       = volume == 3'd0 ? '0
                  : volume == 3'd1 ? period_d >> 4
                  : volume == 3'd2 ? period_d >> 3
                  : volume == 3'd3 ? period_d >> 2
                  : period_d >> 1;
    high_len_d    = (mute || wrap) ? hl_next : high_len_q;
    note_on_d     = en && volume != 3'd0 && period_d != '0;
    cnt_d         = (mute || !note_on_q || wrap) ? '0 : cnt_q + 32'd1;
  end
  assign audio_out = note_on_q && cnt_q < high_len_q;
  assign note_on   = note_on_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_music_tone_gen.sv
// tb_music_tone_gen: randomized and directed checks of music_tone_gen against an arithmetic tone model
module tb_music_tone_gen;
  localparam int CLK = 100_000;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [31:0] tone = 32'd20000;
  logic [2:0]  volume = 3'd4;
  logic        audio_out, note_on, busy;
  int checks = 0, failures = 0;
  music_tone_gen #(.CLK_HZ(CLK)) dut (
    .clk(clk), .rst(rst), .en(en), .tone(tone), .volume(volume),
    .audio_out(audio_out), .note_on(note_on), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic int exp_period(int t);
    return CLK / t;
  endfunction
  function automatic int exp_high(int p, int v);
    int e;
    e = v > 4 ? 4 : v;
    return e == 0 ? 0 : p / (1 << (5 - e));
  endfunction
  task automatic wait_rise(output bit ok);
    logic prev;
    prev = audio_out;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = !prev && audio_out;
      prev = audio_out;
    end
  endtask
  task automatic count_phase(input logic lvl, input int at, input logic [31:0] t, input logic [2:0] v, output int n);
    n = 0;
    while (audio_out === lvl && n < 20000) begin
      if (n == at) begin
        tone = t;
        volume = v;
      end
      n++;
      @(negedge clk);
    end
  endtask
  task automatic edges_until_busy(input logic lvl, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== lvl && k < 200);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({audio_out, note_on, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 000", {audio_out, note_on, busy});
    end
    rst = 1'b0;
  endtask
  task automatic test_silence;
    int seen_audio = 0, seen_note = 0, seen_busy = 0;
    tone = 32'd20000; en = 1'b1; volume = 3'd4;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen_audio += int'(audio_out);
      seen_note += int'(note_on);
      seen_busy += int'(busy);
    end
    checks++;
    if (seen_audio + seen_note !== 0) begin
      failures++;
      $display("FAIL silence_output: got %0d active samples expected 0", seen_audio + seen_note);
    end
    checks++;
    if (seen_busy !== 0) begin
      failures++;
      $display("FAIL silence_busy: got %0d busy samples expected 0", seen_busy);
    end
  endtask
  task automatic check_start(input string name, input int t, input int v);
    int k, hi, lo;
    int p;
    p = exp_period(t);
    edges_until_busy(1'b1, k);
    checks++;
    if (k !== 2) begin
      failures++;
      $display("FAIL %s_busy_rise: got %0d edges expected 2", name, k);
    end
    edges_until_busy(1'b0, k);
    checks++;
    if (k !== 33) begin
      failures++;
      $display("FAIL %s_busy_len: got %0d cycles expected 33", name, k);
    end
    @(negedge clk);
    checks++;
    if ({note_on, audio_out} !== 2'b11) begin
      failures++;
      $display("FAIL %s_first_high: got %b expected 11", name, {note_on, audio_out});
    end
    count_phase(1'b1, -1, tone, volume, hi);
    count_phase(1'b0, -1, tone, volume, lo);
    checks++;
    if (hi !== exp_high(p, v) || lo !== p - exp_high(p, v)) begin
      failures++;
      $display("FAIL %s_wave: got %0d/%0d expected %0d/%0d", name, hi, lo, exp_high(p, v), p - exp_high(p, v));
    end
  endtask
  task automatic test_latency;
    tone = 32'd262; volume = 3'd4;
    check_start("latency", 262, 4);
  endtask
  task automatic test_volume;
    bit ok;
    int hi, lo, hi2, lo2, p;
    p = exp_period(262);
    volume = 3'd1;
    wait_rise(ok);
    count_phase(1'b1, -1, 262, 1, hi);
    count_phase(1'b0, 7, 262, 3, lo);
    count_phase(1'b1, -1, 262, 3, hi2);
    count_phase(1'b0, -1, 262, 3, lo2);
    checks++;
    if (!ok || hi !== exp_high(p, 1) || lo !== p - exp_high(p, 1)) begin
      failures++;
      $display("FAIL vol1_wave: got %0d/%0d expected %0d/%0d", hi, lo, exp_high(p, 1), p - exp_high(p, 1));
    end
    checks++;
    if (hi2 !== exp_high(p, 3) || lo2 !== p - exp_high(p, 3)) begin
      failures++;
      $display("FAIL vol3_after_wrap: got %0d/%0d expected %0d/%0d", hi2, lo2, exp_high(p, 3), p - exp_high(p, 3));
    end
  endtask
  task automatic test_tone_switch;
    bit ok;
    int hi, lo, hi2, lo2, p, q;
    p = exp_period(262);
    q = exp_period(524);
    volume = 3'd4;
    wait_rise(ok);
    count_phase(1'b1, 5, 524, 4, hi);
    count_phase(1'b0, -1, 524, 4, lo);
    count_phase(1'b1, -1, 524, 4, hi2);
    count_phase(1'b0, -1, 524, 4, lo2);
    checks++;
    if (!ok || hi !== exp_high(p, 4) || lo !== p - exp_high(p, 4)) begin
      failures++;
      $display("FAIL switch_old_intact: got %0d/%0d expected %0d/%0d", hi, lo, exp_high(p, 4), p - exp_high(p, 4));
    end
    checks++;
    if (hi2 !== exp_high(q, 4) || lo2 !== q - exp_high(q, 4)) begin
      failures++;
      $display("FAIL switch_new_wave: got %0d/%0d expected %0d/%0d", hi2, lo2, exp_high(q, 4), q - exp_high(q, 4));
    end
  endtask
  task automatic test_abort;
    bit ok;
    int k, hi, lo, p;
    p = exp_period(330);
    tone = 32'd392;
    edges_until_busy(1'b1, k);
    repeat (10) @(negedge clk);
    tone = 32'd330;
    edges_until_busy(1'b0, k);
    checks++;
    if (k !== 35) begin
      failures++;
      $display("FAIL abort_restart_latency: got %0d edges expected 35", k);
    end
    wait_rise(ok);
    count_phase(1'b1, -1, 330, 4, hi);
    count_phase(1'b0, -1, 330, 4, lo);
    checks++;
    if (!ok || hi !== exp_high(p, 4) || lo !== p - exp_high(p, 4)) begin
      failures++;
      $display("FAIL abort_wave: got %0d/%0d expected %0d/%0d", hi, lo, exp_high(p, 4), p - exp_high(p, 4));
    end
  endtask
  task automatic test_enable;
    bit ok;
    int hi;
    wait_rise(ok);
    repeat (3) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({note_on, audio_out} !== 2'b00) begin
      failures++;
      $display("FAIL en_mute: got %b expected 00", {note_on, audio_out});
    end
    repeat (20) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({note_on, audio_out} !== 2'b11) begin
      failures++;
      $display("FAIL en_resume: got %b expected 11", {note_on, audio_out});
    end
    count_phase(1'b1, -1, 330, 4, hi);
    checks++;
    if (!ok || hi !== exp_high(exp_period(330), 4)) begin
      failures++;
      $display("FAIL en_first_high: got %0d expected %0d", hi, exp_high(exp_period(330), 4));
    end
  endtask
  task automatic test_reset_mid;
    bit ok;
    wait_rise(ok);
    repeat (3) @(negedge clk);
    tone = 32'd262;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || {audio_out, note_on, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid: got %b expected 000", {audio_out, note_on, busy});
    end
    rst = 1'b0;
    check_start("reset_resume", 262, 4);
  endtask
  task automatic test_random;
    bit ok;
    int t, v, k, hi, lo, p, last;
    last = 262;
    for (int i = 0; i < 6; i++) begin
      t = int'($urandom_range(6000, 100));
      if (t == last) t++;
      v = int'($urandom_range(7, 1));
      tone = 32'(t);
      volume = 3'(v);
      edges_until_busy(1'b1, k);
      edges_until_busy(1'b0, k);
      wait_rise(ok);
      count_phase(1'b1, -1, tone, volume, hi);
      count_phase(1'b0, -1, tone, volume, lo);
      p = exp_period(t);
      checks++;
      if (!ok || hi !== exp_high(p, v)) begin
        failures++;
        $display("FAIL rand_high tone=%0d vol=%0d: got %0d expected %0d", t, v, hi, exp_high(p, v));
      end
      checks++;
      if (lo !== p - exp_high(p, v)) begin
        failures++;
        $display("FAIL rand_low tone=%0d vol=%0d: got %0d expected %0d", t, v, lo, p - exp_high(p, v));
      end
      last = t;
    end
  endtask
  initial begin
    test_reset;
    test_silence;
    test_latency;
    test_volume;
    test_tone_switch;
    test_abort;
    test_enable;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
